ascii_dec_parse: RTL and testbench

//  Receiving end of our ASCII decimal digit streams. Consumes one character
//  per valid/ready beat and accumulates a run of decimal digits into a binary

---
 rtl/ascii_dec_parse.sv | 157 +++++++++++++++
 tb/tb_ascii_dec_parse.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ascii_dec_parse.sv
// ASCII decimal digit stream parser: accumulates a digit run into a saturating binary value.
// Optional signed parsing with a leading '-' is enabled by defining ASCII_PARSE_SIGN_EN.
module ascii_dec_parse #(
  parameter int         WIDTH = 16,
  parameter logic [7:0] ZERO  = 8'h30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [WIDTH+3:0] UMAX = {4'b0000, {WIDTH{1'b1}}};
`ifdef ASCII_PARSE_SIGN_EN
  localparam logic [WIDTH+3:0] NMAX = {4'b0000, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH+3:0] PMAX = NMAX - 1'b1;
  localparam logic [WIDTH+3:0] LIM_POS = PMAX;
`else
  localparam logic [WIDTH+3:0] LIM_POS = UMAX;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic             latch;
  logic             beat, is_digit;
  logic [7:0]       diff;
  logic [3:0]       d;
  logic [WIDTH+3:0] prod, lim;
`ifdef ASCII_PARSE_SIGN_EN
  logic             neg, neg_nxt, ndig, ndig_nxt;
`endif

  // acc*10 + d, wide enough that no intermediate can wrap
  function automatic logic [WIDTH+3:0] mac10(input logic [WIDTH-1:0] a, input logic [3:0] dd);
    logic [WIDTH+3:0] w;
    w = {4'b0000, a};
    return (w << 3) + (w << 1) + {{WIDTH{1'b0}}, dd};
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH+3:0] v, input logic [WIDTH+3:0] l);
    return (v > l) ? l[WIDTH-1:0] : v[WIDTH-1:0];
  endfunction

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign beat      = in_valid & in_ready;
  assign diff      = in_data - ZERO;
  assign is_digit  = (in_data >= ZERO) && (diff < 8'd10);
  assign d         = diff[3:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    latch     = 1'b0;
    prod      = '0;
`ifdef ASCII_PARSE_SIGN_EN
    neg_nxt   = neg;
    ndig_nxt  = ndig;
    lim       = neg ? NMAX : PMAX;
`else
    lim       = UMAX;
`endif
    case (state)
      IDLE: begin
        if (beat && is_digit) begin
          prod      = mac10('0, d);
          acc_nxt   = sat(prod, LIM_POS);
          ovf_nxt   = (prod > LIM_POS);
          state_nxt = ACC;
`ifdef ASCII_PARSE_SIGN_EN
          neg_nxt   = 1'b0;
          ndig_nxt  = 1'b1;
        end else if (beat && in_data == 8'h2D) begin
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          neg_nxt   = 1'b1;
          ndig_nxt  = 1'b0;
          state_nxt = ACC;
`endif
        end
      end
      ACC: begin
        if (beat && is_digit) begin
`ifdef ASCII_PARSE_SIGN_EN
          ndig_nxt = 1'b1;
`endif
          // once saturated the value is pinned at the limit
          if (!ovf) begin
            prod    = mac10(acc, d);
            acc_nxt = sat(prod, lim);
            ovf_nxt = (prod > lim);
          end
        end else if (beat) begin
`ifdef ASCII_PARSE_SIGN_EN
          if (!ndig) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            latch     = 1'b1;
          end
`else
          state_nxt = HOLD;
          latch     = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_value <= '0;
      out_ovf   <= 1'b0;
`ifdef ASCII_PARSE_SIGN_EN
      neg       <= 1'b0;
      ndig      <= 1'b0;
`endif
    end else begin
      acc <= acc_nxt;
      ovf <= ovf_nxt;
`ifdef ASCII_PARSE_SIGN_EN
      neg  <= neg_nxt;
      ndig <= ndig_nxt;
      if (latch) begin
        out_value <= neg ? -acc : acc;
        out_ovf   <= ovf;
      end
`else
      if (latch) begin
        out_value <= acc;
        out_ovf   <= ovf;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ascii_dec_parse.sv
// Randomized bench for ascii_dec_parse: accepted characters feed a string-level
// reference model whose results are compared against every HOLD cycle of the DUT.
module tb_ascii_dec_parse;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_value;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  ascii_dec_parse #(.WIDTH(WIDTH), .ZERO(8'h30)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_value(out_value), .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] val;
    logic             ovf;
  } res_t;

  res_t       exp_q[$];
  byte unsigned stream[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  // reference model state: number in progress, magnitude, flags
  bit         m_in;
  longint     m_v;
  bit         m_ovf, m_neg, m_ndig;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
  endtask

  task automatic model_reset();
    m_in = 0; m_v = 0; m_ovf = 0; m_neg = 0; m_ndig = 0;
  endtask

  function automatic longint limit(input bit neg);
`ifdef ASCII_PARSE_SIGN_EN
    return neg ? (longint'(1) << (WIDTH-1)) : (longint'(1) << (WIDTH-1)) - 1;
`else
    return (longint'(1) << WIDTH) - 1;
`endif
  endfunction

  task automatic model_char(input byte unsigned c);
    bit   dig;
    res_t r;
    dig = (c >= 8'h30) && (c <= 8'h39);
    if (!m_in) begin
      if (dig) begin
        m_in = 1; m_neg = 0; m_ndig = 1; m_ovf = 0; m_v = c - 8'h30;
        if (m_v > limit(0)) begin m_v = limit(0); m_ovf = 1; end
`ifdef ASCII_PARSE_SIGN_EN
      end else if (c == 8'h2D) begin
        m_in = 1; m_neg = 1; m_ndig = 0; m_ovf = 0; m_v = 0;
`endif
      end
    end else if (dig) begin
      m_ndig = 1;
      m_v = m_v * 10 + (c - 8'h30);
      if (m_v > limit(m_neg)) begin m_v = limit(m_neg); m_ovf = 1; end
    end else begin
      m_in = 0;
      if (m_ndig) begin
        r.val = m_neg ? WIDTH'(-m_v) : WIDTH'(m_v);
        r.ovf = m_ovf;
        exp_q.push_back(r);
      end
    end
  endtask

  initial begin
    bit rst_now, rst_prev, took;
    int ndig;
    byte unsigned c;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    model_reset();

    add_str("1234 "); add_str("65535\n"); add_str("65536,"); add_str("0000007;");
    add_str("  x42;"); add_str("9;8;"); add_str("5 "); add_str("6 ");
    add_str("999999999 "); add_str("00000000000065535 ");
`ifdef ASCII_PARSE_SIGN_EN
    add_str("-32768 "); add_str("-40000 "); add_str("32768 "); add_str("- ");
    add_str("32767 "); add_str("12-3 ");
`endif
    for (int t = 0; t < 300; t++) begin
`ifdef ASCII_PARSE_SIGN_EN
      if ($urandom_range(0, 3) == 0) stream.push_back(8'h2D);
`endif
      ndig = $urandom_range(0, 7);
      for (int k = 0; k < ndig; k++) stream.push_back(8'(8'h30 + $urandom_range(0, 9)));
      do c = 8'($urandom_range(0, 255)); while (c >= 8'h30 && c <= 8'h39);
      stream.push_back(c);
    end

    repeat (2) @(posedge clk);
    rst_prev = 1'b1;
    took     = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (stream.size() == 0 && !in_valid && exp_q.size() == 0 && cyc > 10) break;
      @(negedge clk);
      rst_now   = (cyc > 5) && ($urandom_range(0, 199) == 0);
      rst       = rst_now;
      out_ready = (cyc < 5) || ($urandom_range(0, 3) != 0);

      if (rst_prev) begin
        chk("rst_value", out_value, 0);
        chk("rst_ovf", out_ovf, 0);
      end
      chk("in_ready", in_ready, !out_valid);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        chk("out_value", out_value, exp_q[0].val);
        chk("out_ovf", out_ovf, exp_q[0].ovf);
        if (out_ready && !rst_now) void'(exp_q.pop_front());
      end
      if (rst_now) begin
        exp_q.delete();
        model_reset();
      end

      if (took) begin in_valid = 1'b0; took = 1'b0; end
      if (!in_valid && stream.size() != 0 && $urandom_range(0, 3) != 0) begin
        in_data  = stream.pop_front();
        in_valid = 1'b1;
      end
      if (in_valid && in_ready && !rst_now) begin
        model_char(in_data);
        took = 1'b1;
      end
      rst_prev = rst_now;
    end

    @(negedge clk);
    if (took) in_valid = 1'b0;
    chk("drain", stream.size() + int'(in_valid && !took) + exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
